// File: rtl/spi_cmd_pkg.sv
// Shared constants for the SPI command controller: opcodes, error codes,
// issue FSM encoding, frame field positions and the frame checksum helper.
package spi_cmd_pkg;

    localparam logic [7:0] OPC_WRITE = 8'h01;
    localparam logic [7:0] OPC_CLR   = 8'h02;
    localparam logic [7:0] OPC_FLUSH = 8'h03;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_LEN  = 3'd1;
    localparam logic [2:0] ERR_SYNC = 3'd2;
    localparam logic [2:0] ERR_CKS  = 3'd3;
    localparam logic [2:0] ERR_OPC  = 3'd4;
    localparam logic [2:0] ERR_OVF  = 3'd5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } issue_state_e;

    localparam int FRAME_W   = 64;
    localparam int SYNC_MSB  = 63;
    localparam int SYNC_LSB  = 56;
    localparam int OPC_MSB   = 55;
    localparam int OPC_LSB   = 48;
    localparam int ADDR_MSB  = 47;
    localparam int ADDR_LSB  = 40;
    localparam int DATA_MSB  = 39;
    localparam int DATA_LSB  = 8;
    localparam int CKS_MSB   = 7;
    localparam int CKS_LSB   = 0;
    localparam int ENTRY_W   = 40;

    // XOR of every byte above the checksum byte.
    function automatic logic [7:0] frame_cksum(input logic [FRAME_W-1:0] f);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 1; i < 8; i++) begin
            acc = acc ^ f[i*8 +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO holding queued {addr, data} write commands.
// Head entry is presented combinationally on rdata while not empty.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == (AW+1)'(0));
    assign level     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    // A push into a full FIFO is only allowed when the head leaves in the same cycle.
    assign do_push_s = push && (!full || pop);
    assign do_pop_s  = pop && !empty;

    // Storage write; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; flush discards everything queued.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command controller: validates captured frames, executes local
// commands, queues writes and issues them on the config bus one at a time.
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_valid,
    input  logic [7:0]                    frame_bits,
    input  logic [63:0]                   frame_data,
    output logic                          cfg_wr_en,
    output logic [7:0]                    cfg_addr,
    output logic [31:0]                   cfg_wdata,
    input  logic                          cfg_ready,
    output logic [CNT_W-1:0]              good_cnt,
    output logic [CNT_W-1:0]              err_cnt,
    output logic [2:0]                    err_code,
    output logic                          err_pulse,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    logic                 d_valid_r;
    logic [7:0]           d_bits_r;
    logic [63:0]          d_frame_r;
    logic [2:0]           err_s;
    logic                 push_s;
    logic                 clr_s;
    logic                 flush_s;
    logic                 pop_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [ENTRY_W-1:0]   head_s;
    issue_state_e         state_r;
    issue_state_e         next_state_s;
    logic                 cfg_wr_en_r;
    logic [7:0]           cfg_addr_r;
    logic [31:0]          cfg_wdata_r;
    logic [CNT_W-1:0]     good_cnt_r;
    logic [CNT_W-1:0]     err_cnt_r;
    logic [2:0]           err_code_r;
    logic                 err_pulse_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Capture the frame so decode sees stable fields during stage D.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_valid_r <= 1'b0;
            d_bits_r  <= 8'h00;
            d_frame_r <= 64'h0;
        end else begin
            d_valid_r <= frame_valid;
            if (frame_valid) begin
                d_bits_r  <= frame_bits;
                d_frame_r <= frame_data;
            end
        end
    end

    // Stage D decode: prioritised checks, then opcode dispatch.
    always_comb begin
        err_s   = ERR_NONE;
        push_s  = 1'b0;
        clr_s   = 1'b0;
        flush_s = 1'b0;
        if (d_valid_r) begin
            if (d_bits_r != 8'd64) begin
                err_s = ERR_LEN;
            end else if (d_frame_r[SYNC_MSB:SYNC_LSB] != SYNC_BYTE) begin
                err_s = ERR_SYNC;
            end else if (frame_cksum(d_frame_r) != d_frame_r[CKS_MSB:CKS_LSB]) begin
                err_s = ERR_CKS;
            end else begin
                case (d_frame_r[OPC_MSB:OPC_LSB])
                    OPC_WRITE: begin
                        // A head leaving this cycle frees the slot for the push.
                        if (fifo_full_s && !pop_s) begin
                            err_s = ERR_OVF;
                        end else begin
                            push_s = 1'b1;
                        end
                    end
                    OPC_CLR:   clr_s   = 1'b1;
                    OPC_FLUSH: flush_s = 1'b1;
                    default:   err_s   = ERR_OPC;
                endcase
            end
        end else begin
            err_s = ERR_NONE;
        end
    end

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .wdata (d_frame_r[ADDR_MSB:DATA_LSB]),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level)
    );

    // Issue FSM next state: pop on leaving IDLE, hold ISSUE until accepted.
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    next_state_s = ISSUE;
                    pop_s        = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: begin
                if (cfg_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = ISSUE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Issue FSM state and registered config bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cfg_wr_en_r <= 1'b0;
            cfg_addr_r  <= 8'h00;
            cfg_wdata_r <= 32'h0;
        end else begin
            state_r     <= next_state_s;
            cfg_wr_en_r <= (next_state_s == ISSUE);
            if (pop_s) begin
                cfg_addr_r  <= head_s[ENTRY_W-1:32];
                cfg_wdata_r <= head_s[31:0];
            end
        end
    end

    // Statistics: clear beats increment; counters saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            good_cnt_r  <= {CNT_W{1'b0}};
            err_cnt_r   <= {CNT_W{1'b0}};
            err_code_r  <= ERR_NONE;
            err_pulse_r <= 1'b0;
        end else begin
            err_pulse_r <= (err_s != ERR_NONE);
            if (clr_s) begin
                good_cnt_r <= {CNT_W{1'b0}};
                err_cnt_r  <= {CNT_W{1'b0}};
                err_code_r <= ERR_NONE;
            end else if (err_s != ERR_NONE) begin
                err_cnt_r  <= sat_inc(err_cnt_r);
                err_code_r <= err_s;
            end else if (d_valid_r) begin
                good_cnt_r <= sat_inc(good_cnt_r);
            end
        end
    end

    assign cfg_wr_en = cfg_wr_en_r;
    assign cfg_addr  = cfg_addr_r;
    assign cfg_wdata = cfg_wdata_r;
    assign good_cnt  = good_cnt_r;
    assign err_cnt   = err_cnt_r;
    assign err_code  = err_code_r;
    assign err_pulse = err_pulse_r;
    assign busy      = cfg_wr_en_r || !fifo_empty_s;

endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
Command controller downstream of the 64-bit SPI slave receiver. It validates each captured frame (length, sync byte, checksum, opcode) and executes local commands. Write commands are queued in a small FIFO and issued one at a time to the configuration register bus using a valid/ready handshake. It also keeps good-frame and error statistics for host readback.

Parameters:
FIFO_DEPTH, 4, number of queued write commands (power of two, 2..16)
SYNC_BYTE, 8'hA5, required value of frame bits [63:56]
CNT_W, 16, width of the saturating statistics counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
frame_valid  in  1  one-cycle pulse: frame captured (asserted after SSEL deasserts)
frame_bits  in  8  count of SCK rising edges in the frame
frame_data  in  64  captured frame, MSB first on the wire
cfg_wr_en  out  1  write request to the config bus; held until accepted
cfg_addr  out  8  config register address
cfg_wdata  out  32  config write data
cfg_ready  in  1  config bus accepts the write when cfg_wr_en && cfg_ready
good_cnt  out  CNT_W  frames accepted
err_cnt  out  CNT_W  frames rejected
err_code  out  3  code of the last error (sticky)
err_pulse  out  1  one-cycle pulse per rejected frame
fifo_level  out  $clog2(FIFO_DEPTH)+1  queued entries
busy  out  1  FIFO non-empty or a write is in flight

Behaviour:
- Reset: one clock, synchronous active-high. All outputs are 0 after reset. FIFO is emptied, counters are cleared, the FSM is in IDLE, and any in-flight write is abandoned.
- Frame format: [63:56] sync, [55:48] opcode, [47:40] addr, [39:8] data, [7:0] checksum. The checksum is the XOR of bytes [63:56] through [15:8].
- Stage D (decode): registered on the cycle after frame_valid. frame_valid is ignored while rst=1.
- Error checks, in priority order, first match wins:
  - 1 LEN: frame_bits != 64
  - 2 SYNC: sync byte != SYNC_BYTE
  - 3 CKS: checksum mismatch
  - 4 OPC: undefined opcode
  - 5 OVF: WRITE opcode while the FIFO is full
- On an error: the frame is dropped, err_cnt increments, err_code is updated, and err_pulse fires in stage D.
- Opcodes:
  - 0x01 WRITE: push {addr, data} to the FIFO.
  - 0x02 CLR_STATS: zero good_cnt, err_cnt and err_code. The clear takes priority over the increment for this frame, so all three read 0 afterwards.
  - 0x03 FLUSH: empty the FIFO. A write already in ISSUE completes normally.
  - Every valid frame, including 0x02 and 0x03, increments good_cnt.
- Counters saturate at all-ones.
- FIFO full check uses the occupancy at stage D, including a pop happening in the same cycle. A pop and a push in the same cycle are legal.
- Issue FSM:
  - IDLE: go to ISSUE when the FIFO is non-empty. On that edge, pop the head and load cfg_addr and cfg_wdata.
  - ISSUE: cfg_wr_en=1. cfg_addr and cfg_wdata are stable until the handshake. On cfg_ready=1, go to IDLE; cfg_wr_en drops the next cycle.
  - Back-to-back writes insert one IDLE cycle between them.
- Latency: with the FIFO empty and the FSM in IDLE, frame_valid at cycle N gives cfg_wr_en=1 at cycle N+3.
- Addr and data pass through unmodified. No range check is applied to addr.
- A new frame_valid while decode is busy cannot occur, because frames are at least 64 SCK periods apart; no backpressure to the slave is needed.

Decomposition:
- Package spi_cmd_pkg holds:
  - opcode constants OPC_WRITE=8'h01, OPC_CLR=8'h02, OPC_FLUSH=8'h03
  - error codes ERR_NONE..ERR_OVF (3-bit)
  - FSM state encoding IDLE/ISSUE
  - frame field bit positions
- Sub-module cmd_fifo: synchronous FIFO, 40-bit entries, FIFO_DEPTH deep. Ports: push, pop, flush, full, empty, level; data out is valid at the head.
- Decode, statistics and the FSM stay in the top module.

Test Plan:
- Valid write: frame 64'hA5_01_10_DEADBEEF_96, bits=64, cfg_ready=1 → cfg_wr_en=1 at N+3 with addr 8'h10 and wdata 32'hDEADBEEF for one cycle; good_cnt=1; err_pulse stays 0.
- Errors: same frame with bits=63 → err_code=1; sync changed to 8'h5A → err_code=2; last byte 8'h97 → err_code=3; opcode 8'h7F (checksum fixed) → err_code=4. Each gives err_cnt+1 and no cfg_wr_en.
- Overflow and backpressure: hold cfg_ready=0 and send 6 valid writes → first issued and held with stable addr/data; fifo_level=4; 6th write gives err_code=5. Release cfg_ready → the 5 accepted writes complete in order, each separated by one IDLE cycle.
- Flush mid-issue: with 3 writes queued and one in ISSUE, send FLUSH (A5_03_…) → in-flight write completes on cfg_ready; fifo_level=0; no further cfg_wr_en; good_cnt increments.
- Stats and saturation: force err_cnt to 16'hFFFF and send a bad frame → stays 16'hFFFF. Send CLR_STATS → good_cnt=0, err_cnt=0, err_code=0.
- Reset mid-operation: assert rst while cfg_wr_en=1 with 2 entries queued → next cycle cfg_wr_en=0, fifo_level=0, busy=0, counters 0.
